// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding plus load-use stall / taken-branch flush sequencing.
// Define HAZ_PERF_CNT_EN to build the saturating StallCount performance counter.
module hazard_forward_unit #(
    parameter int unsigned RA_W         = 5,
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned REG_ZERO     = 31,
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                      Clk,
    input  logic                      RstN,
    input  logic                      Branching,
    input  logic [NUM_SRC*RA_W-1:0]   IFID_Src,
    input  logic                      IDEX_MemRead,
    input  logic [RA_W-1:0]           IDEX_WriteRegister,
    input  logic [NUM_SRC*RA_W-1:0]   IDEX_Src,
    input  logic                      EXMEM_RegWrite,
    input  logic                      MEMWB_RegWrite,
    input  logic [RA_W-1:0]           EXMEM_WriteRegister,
    input  logic [RA_W-1:0]           MEMWB_WriteRegister,
    output logic [2*NUM_SRC-1:0]      ForwardSel,
    output logic                      Stall,
    output logic                      Flush,
    output logic [15:0]               StallCount
);

    localparam logic [RA_W-1:0] ZERO_REG     = RA_W'(REG_ZERO);
    localparam logic [3:0]      FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
    localparam logic [3:0]      STALL_RELOAD = (LOAD_LAT > 1)     ? 4'(LOAD_LAT - 2)     : 4'd0;

    typedef enum logic [1:0] {
        S_RUN,
        S_STALL,
        S_FLUSH
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use;

    always_comb begin
        ForwardSel = '0;
        if (RstN && !Branching) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (EXMEM_RegWrite && EXMEM_WriteRegister == IDEX_Src[i*RA_W +: RA_W]
                    && IDEX_Src[i*RA_W +: RA_W] != ZERO_REG) begin
                    ForwardSel[2*i +: 2] = 2'b10;
                end else if (MEMWB_RegWrite && MEMWB_WriteRegister == IDEX_Src[i*RA_W +: RA_W]
                             && IDEX_Src[i*RA_W +: RA_W] != ZERO_REG) begin
                    ForwardSel[2*i +: 2] = 2'b01;
                end
            end
        end
    end

    always_comb begin
        load_use = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (IDEX_MemRead && IDEX_WriteRegister != ZERO_REG
                && IDEX_WriteRegister == IFID_Src[i*RA_W +: RA_W]) begin
                load_use = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Detection cycle already counts as the first stall/flush cycle, hence the -2 reloads.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (Branching) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = S_FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = S_RUN;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (load_use && LOAD_LAT > 1) begin
                        state_d = S_STALL;
                        cnt_d   = STALL_RELOAD;
                    end
                end
                S_STALL, S_FLUSH: begin
                    if (cnt_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_comb begin
        Stall = 1'b0;
        Flush = 1'b0;
        if (RstN) begin
            case (state_q)
                S_RUN: begin
                    if (Branching) begin
                        Flush = 1'b1;
                    end else if (load_use) begin
                        Stall = 1'b1;
                    end
                end
                S_STALL: begin
                    if (Branching) begin
                        Flush = 1'b1;
                    end else begin
                        Stall = 1'b1;
                    end
                end
                S_FLUSH: Flush = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: three instances with different
// load/flush lengths share one stimulus stream; expectations are queued per cycle.
module tb_hazard_forward_unit;

    localparam int RA_W    = 5;
    localparam int NUM_SRC = 2;
`ifdef HAZ_PERF_CNT_EN
    localparam logic [31:0] EXP_CNT3 = 32'd3;
`else
    localparam logic [31:0] EXP_CNT3 = 32'd0;
`endif

    localparam int SEL_FS_A = 0, SEL_ST_A = 1, SEL_FL_A = 2, SEL_CNT_A = 3;
    localparam int SEL_FS_B = 4, SEL_ST_B = 5, SEL_FL_B = 6;
    localparam int SEL_FS_C = 7, SEL_ST_C = 8, SEL_FL_C = 9;

    logic                    Clk = 1'b0;
    logic                    RstN;
    logic                    Branching;
    logic [NUM_SRC*RA_W-1:0] IFID_Src;
    logic                    IDEX_MemRead;
    logic [RA_W-1:0]         IDEX_WriteRegister;
    logic [NUM_SRC*RA_W-1:0] IDEX_Src;
    logic                    EXMEM_RegWrite, MEMWB_RegWrite;
    logic [RA_W-1:0]         EXMEM_WriteRegister, MEMWB_WriteRegister;

    logic [2*NUM_SRC-1:0] fs_a, fs_b, fs_c;
    logic                 st_a, st_b, st_c, fl_a, fl_b, fl_c;
    logic [15:0]          cnt_a, cnt_b, cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    always #5 Clk = ~Clk;

    // u_a: LOAD_LAT=3/FLUSH=2, u_b: LOAD_LAT=4/FLUSH=2, u_c: LOAD_LAT=1/FLUSH=5
    hazard_forward_unit #(.RA_W(RA_W), .NUM_SRC(NUM_SRC), .REG_ZERO(31), .LOAD_LAT(3), .FLUSH_CYCLES(2)) u_a (
        .Clk(Clk), .RstN(RstN), .Branching(Branching), .IFID_Src(IFID_Src),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_WriteRegister(IDEX_WriteRegister), .IDEX_Src(IDEX_Src),
        .EXMEM_RegWrite(EXMEM_RegWrite), .MEMWB_RegWrite(MEMWB_RegWrite),
        .EXMEM_WriteRegister(EXMEM_WriteRegister), .MEMWB_WriteRegister(MEMWB_WriteRegister),
        .ForwardSel(fs_a), .Stall(st_a), .Flush(fl_a), .StallCount(cnt_a));

    hazard_forward_unit #(.RA_W(RA_W), .NUM_SRC(NUM_SRC), .REG_ZERO(31), .LOAD_LAT(4), .FLUSH_CYCLES(2)) u_b (
        .Clk(Clk), .RstN(RstN), .Branching(Branching), .IFID_Src(IFID_Src),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_WriteRegister(IDEX_WriteRegister), .IDEX_Src(IDEX_Src),
        .EXMEM_RegWrite(EXMEM_RegWrite), .MEMWB_RegWrite(MEMWB_RegWrite),
        .EXMEM_WriteRegister(EXMEM_WriteRegister), .MEMWB_WriteRegister(MEMWB_WriteRegister),
        .ForwardSel(fs_b), .Stall(st_b), .Flush(fl_b), .StallCount(cnt_b));

    hazard_forward_unit #(.RA_W(RA_W), .NUM_SRC(NUM_SRC), .REG_ZERO(31), .LOAD_LAT(1), .FLUSH_CYCLES(5)) u_c (
        .Clk(Clk), .RstN(RstN), .Branching(Branching), .IFID_Src(IFID_Src),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_WriteRegister(IDEX_WriteRegister), .IDEX_Src(IDEX_Src),
        .EXMEM_RegWrite(EXMEM_RegWrite), .MEMWB_RegWrite(MEMWB_RegWrite),
        .EXMEM_WriteRegister(EXMEM_WriteRegister), .MEMWB_WriteRegister(MEMWB_WriteRegister),
        .ForwardSel(fs_c), .Stall(st_c), .Flush(fl_c), .StallCount(cnt_c));

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            SEL_FS_A:  return 32'(fs_a);
            SEL_ST_A:  return 32'(st_a);
            SEL_FL_A:  return 32'(fl_a);
            SEL_CNT_A: return 32'(cnt_a);
            SEL_FS_B:  return 32'(fs_b);
            SEL_ST_B:  return 32'(st_b);
            SEL_FL_B:  return 32'(fl_b);
            SEL_FS_C:  return 32'(fs_c);
            SEL_ST_C:  return 32'(st_c);
            SEL_FL_C:  return 32'(fl_c);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_v(input int sel, input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs(e.sel), e.exp);
        end
    endtask

    // Inputs change at posedge+1; combinational outputs are scored at the negedge.
    task automatic cycle();
        @(negedge Clk);
        drain();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        Branching           = 1'b0;
        IFID_Src            = '0;
        IDEX_MemRead        = 1'b0;
        IDEX_WriteRegister  = '0;
        IDEX_Src            = '0;
        EXMEM_RegWrite      = 1'b0;
        MEMWB_RegWrite      = 1'b0;
        EXMEM_WriteRegister = '0;
        MEMWB_WriteRegister = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RstN = 1'b0;
        @(posedge Clk);
        #1;
        RstN = 1'b1;
    endtask

    initial begin
        clear_inputs();
        RstN = 1'b0;
        @(posedge Clk);
        #1;

        // Reset with every hazard input active: outputs must stay quiet
        Branching = 1'b1; EXMEM_RegWrite = 1'b1; EXMEM_WriteRegister = 5'd3;
        IDEX_Src = {5'd3, 5'd3}; IDEX_MemRead = 1'b1; IDEX_WriteRegister = 5'd5;
        IFID_Src = {5'd5, 5'd5};
        expect_v(SEL_FS_A,  "rst_fwd",     32'd0);
        expect_v(SEL_FL_A,  "rst_flush",   32'd0);
        expect_v(SEL_ST_A,  "rst_stall",   32'd0);
        expect_v(SEL_CNT_A, "rst_cnt",     32'd0);
        expect_v(SEL_FL_C,  "rst_flush_c", 32'd0);
        cycle();
        clear_inputs();
        RstN = 1'b1;

        // Forwarding priority
        EXMEM_RegWrite = 1'b1; EXMEM_WriteRegister = 5'd3;
        MEMWB_RegWrite = 1'b1; MEMWB_WriteRegister = 5'd3;
        IDEX_Src = {5'd3, 5'd3};
        expect_v(SEL_FS_A, "fwd_ex_prio", 32'b1010);
        cycle();
        EXMEM_RegWrite = 1'b0;
        expect_v(SEL_FS_A, "fwd_mem", 32'b0101);
        cycle();
        EXMEM_RegWrite = 1'b1; EXMEM_WriteRegister = 5'd7;
        IDEX_Src = {5'd7, 5'd3};
        expect_v(SEL_FS_A, "fwd_mixed",   32'b1001);
        expect_v(SEL_FS_C, "fwd_mixed_c", 32'b1001);
        cycle();

        // XZR guard
        clear_inputs();
        EXMEM_RegWrite = 1'b1; EXMEM_WriteRegister = 5'd31;
        IDEX_Src = {5'd5, 5'd31};
        expect_v(SEL_FS_A, "xzr_ex", 32'd0);
        cycle();
        EXMEM_RegWrite = 1'b0; MEMWB_RegWrite = 1'b1; MEMWB_WriteRegister = 5'd31;
        expect_v(SEL_FS_A, "xzr_mem", 32'd0);
        cycle();
        clear_inputs();
        IDEX_MemRead = 1'b1; IDEX_WriteRegister = 5'd31; IFID_Src = {5'd31, 5'd31};
        expect_v(SEL_ST_A, "xzr_load0", 32'd0);
        cycle();
        expect_v(SEL_ST_A, "xzr_load1", 32'd0);
        cycle();

        // Branching masks forwarding and starts a 2-cycle flush on u_a
        clear_inputs();
        EXMEM_RegWrite = 1'b1; EXMEM_WriteRegister = 5'd3; IDEX_Src = {5'd3, 5'd3};
        Branching = 1'b1;
        expect_v(SEL_FS_A, "br_fwd_mask", 32'd0);
        expect_v(SEL_FL_A, "br_flush0",   32'd1);
        expect_v(SEL_ST_A, "br_stall0",   32'd0);
        cycle();
        Branching = 1'b0;
        expect_v(SEL_FS_A, "br_fwd_back", 32'b1010);
        expect_v(SEL_FL_A, "br_flush1",   32'd1);
        cycle();
        expect_v(SEL_FL_A, "br_flush_end", 32'd0);
        cycle();

        // Multi-cycle load-use: u_a 3 cycles, u_b 4, u_c 1 per hit
        do_reset();
        IDEX_MemRead = 1'b1; IDEX_WriteRegister = 5'd5; IFID_Src = {5'd5, 5'd0};
        expect_v(SEL_ST_A, "lu_stall0",   32'd1);
        expect_v(SEL_ST_C, "lu_stall0_c", 32'd1);
        cycle();
        expect_v(SEL_ST_A, "lu_stall1", 32'd1);
        cycle();
        expect_v(SEL_ST_A, "lu_stall2", 32'd1);
        cycle();
        clear_inputs();
        expect_v(SEL_ST_A, "lu_stall3_off", 32'd0);
        expect_v(SEL_ST_B, "lu_stall3_b",   32'd1);
        cycle();
        expect_v(SEL_ST_A,  "lu_stall4_off",  32'd0);
        expect_v(SEL_ST_B,  "lu_stall4_b",    32'd0);
        expect_v(SEL_CNT_A, "lu_stall_count", EXP_CNT3);
        cycle();

        // Hit still present when RUN is re-entered is detected that cycle
        do_reset();
        IDEX_MemRead = 1'b1; IDEX_WriteRegister = 5'd9; IFID_Src = {5'd0, 5'd9};
        cycle();
        cycle();
        cycle();
        expect_v(SEL_ST_A, "lu_redetect", 32'd1);
        cycle();

        // Branch during stall (u_b)
        do_reset();
        EXMEM_RegWrite = 1'b1; EXMEM_WriteRegister = 5'd3; IDEX_Src = {5'd3, 5'd3};
        IDEX_MemRead = 1'b1; IDEX_WriteRegister = 5'd5; IFID_Src = {5'd5, 5'd0};
        expect_v(SEL_ST_B, "bds_stall0", 32'd1);
        expect_v(SEL_FL_B, "bds_flush0", 32'd0);
        cycle();
        Branching = 1'b1;
        expect_v(SEL_ST_B, "bds_stall1", 32'd0);
        expect_v(SEL_FL_B, "bds_flush1", 32'd1);
        expect_v(SEL_FS_B, "bds_fwd1",   32'd0);
        cycle();
        Branching = 1'b0; IDEX_MemRead = 1'b0;
        expect_v(SEL_ST_B, "bds_stall2", 32'd0);
        expect_v(SEL_FL_B, "bds_flush2", 32'd1);
        expect_v(SEL_FS_B, "bds_fwd2",   32'b1010);
        cycle();
        expect_v(SEL_ST_B, "bds_stall3", 32'd0);
        expect_v(SEL_FL_B, "bds_flush3", 32'd0);
        cycle();

        // Reset in the 2nd flush cycle of u_c
        do_reset();
        Branching = 1'b1;
        expect_v(SEL_FL_C, "rmf_flush0", 32'd1);
        cycle();
        Branching = 1'b0;
        expect_v(SEL_FL_C, "rmf_flush1", 32'd1);
        @(negedge Clk);
        drain();
        RstN = 1'b0;
        #1;
        expect_v(SEL_FL_C, "rmf_async_flush", 32'd0);
        expect_v(SEL_ST_C, "rmf_async_stall", 32'd0);
        drain();
        @(posedge Clk);
        #1;
        RstN = 1'b1;
        expect_v(SEL_FL_C, "rmf_post0", 32'd0);
        cycle();
        expect_v(SEL_FL_C, "rmf_post1", 32'd0);
        cycle();
        expect_v(SEL_FL_C, "rmf_post2", 32'd0);
        cycle();

        // Back-to-back branches on u_a: 3 flush cycles total
        do_reset();
        Branching = 1'b1;
        expect_v(SEL_FL_A, "b2b_flush0", 32'd1);
        cycle();
        expect_v(SEL_FL_A, "b2b_flush1", 32'd1);
        cycle();
        Branching = 1'b0;
        expect_v(SEL_FL_A, "b2b_flush2", 32'd1);
        cycle();
        expect_v(SEL_FL_A, "b2b_flush3", 32'd0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
